// File: rtl/datapath_seq_pkg.sv
// Shared types and constants for the datapath sequencer: command kinds,
// FSM states and the ALU function codes the host side relies on.
package datapath_seq_pkg;

    localparam int ALUFN_W = 5;

    localparam logic [ALUFN_W-1:0] ALUFN_ADD = 5'b00001;
    localparam logic [ALUFN_W-1:0] ALUFN_SUB = 5'b10001;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_LOADI = 2'd1,
        CMD_ALU   = 2'd2,
        CMD_READ  = 2'd3
    } cmd_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/datapath_sequencer.sv
// Command-driven controller for a register-file/ALU datapath: one command per
// handshake, a single EXEC cycle on the datapath, then a held response.
module datapath_sequencer
    import datapath_seq_pkg::*;
#(
    parameter int Nloc  = 32,
    parameter int Dbits = 8,
    parameter int CNTW  = 16,
    localparam int AW   = $clog2(Nloc)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_kind,
    input  logic               cmd_wb,
    input  logic [AW-1:0]      cmd_rd,
    input  logic [AW-1:0]      cmd_rs1,
    input  logic [AW-1:0]      cmd_rs2,
    input  logic [ALUFN_W-1:0] cmd_alufn,
    input  logic [Dbits-1:0]   cmd_imm,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [Dbits-1:0]   rsp_data,
    output logic               rsp_zero,
    output logic               busy,
    output logic [CNTW-1:0]    ops_count,
    output logic               dp_RegWrite,
    output logic [AW-1:0]      dp_ReadAddr1,
    output logic [AW-1:0]      dp_ReadAddr2,
    output logic [AW-1:0]      dp_WriteAddr,
    output logic [ALUFN_W-1:0] dp_ALUFN,
    output logic [Dbits-1:0]   dp_WriteData,
    input  logic [Dbits-1:0]   dp_ReadData1,
    input  logic [Dbits-1:0]   dp_ALUResult,
    input  logic               dp_FlagZ
);

    state_t               state_r;
    state_t               state_nx_s;
    cmd_kind_t            kind_r;
    logic                 wb_r;
    logic [AW-1:0]        rd_r;
    logic [AW-1:0]        rs1_r;
    logic [AW-1:0]        rs2_r;
    logic [ALUFN_W-1:0]   alufn_r;
    logic [Dbits-1:0]     imm_r;
    logic [Dbits-1:0]     rsp_data_r;
    logic                 rsp_zero_r;
    logic [CNTW-1:0]      ops_r;

    logic [Dbits-1:0]     result_s;
    logic                 zero_s;
    logic                 regwrite_s;
    logic [Dbits-1:0]     wdata_s;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state plus the EXEC-cycle datapath drive and result selection.
    always_comb begin
        state_nx_s = state_r;
        result_s   = {Dbits{1'b0}};
        zero_s     = 1'b1;
        regwrite_s = 1'b0;
        wdata_s    = imm_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nx_s = ST_EXEC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nx_s = ST_RESP;
                case (kind_r)
                    CMD_LOADI: begin
                        regwrite_s = 1'b1;
                        result_s   = imm_r;
                        zero_s     = (imm_r == {Dbits{1'b0}});
                    end
                    CMD_ALU: begin
                        // Write data is the live ALU output fed straight back.
                        regwrite_s = wb_r;
                        wdata_s    = dp_ALUResult;
                        result_s   = dp_ALUResult;
                        zero_s     = dp_FlagZ;
                    end
                    CMD_READ: begin
                        result_s = dp_ReadData1;
                        zero_s   = (dp_ReadData1 == {Dbits{1'b0}});
                    end
                    CMD_NOP: begin
                        result_s = {Dbits{1'b0}};
                        zero_s   = 1'b1;
                    end
                    default: begin
                        result_s = {Dbits{1'b0}};
                        zero_s   = 1'b1;
                    end
                endcase
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Command capture on the IDLE handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            kind_r  <= CMD_NOP;
            wb_r    <= 1'b0;
            rd_r    <= {AW{1'b0}};
            rs1_r   <= {AW{1'b0}};
            rs2_r   <= {AW{1'b0}};
            alufn_r <= {ALUFN_W{1'b0}};
            imm_r   <= {Dbits{1'b0}};
        end else if ((state_r == ST_IDLE) && cmd_valid) begin
            kind_r  <= cmd_kind_t'(cmd_kind);
            wb_r    <= cmd_wb;
            rd_r    <= cmd_rd;
            rs1_r   <= cmd_rs1;
            rs2_r   <= cmd_rs2;
            alufn_r <= cmd_alufn;
            imm_r   <= cmd_imm;
        end else begin
            kind_r  <= kind_r;
            wb_r    <= wb_r;
            rd_r    <= rd_r;
            rs1_r   <= rs1_r;
            rs2_r   <= rs2_r;
            alufn_r <= alufn_r;
            imm_r   <= imm_r;
        end
    end

    // Response capture at the end of EXEC; held stable through RESP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_data_r <= {Dbits{1'b0}};
            rsp_zero_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            rsp_data_r <= result_s;
            rsp_zero_r <= zero_s;
        end else begin
            rsp_data_r <= rsp_data_r;
            rsp_zero_r <= rsp_zero_r;
        end
    end

    // Completed-response counter, wraps naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ops_r <= {CNTW{1'b0}};
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            ops_r <= ops_r + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            ops_r <= ops_r;
        end
    end

    assign cmd_ready    = (state_r == ST_IDLE);
    assign busy         = (state_r != ST_IDLE);
    assign rsp_valid    = (state_r == ST_RESP);
    assign rsp_data     = rsp_data_r;
    assign rsp_zero     = rsp_zero_r;
    assign ops_count    = ops_r;
    assign dp_RegWrite  = regwrite_s;
    assign dp_ReadAddr1 = rs1_r;
    assign dp_ReadAddr2 = rs2_r;
    assign dp_WriteAddr = rd_r;
    assign dp_ALUFN     = alufn_r;
    assign dp_WriteData = wdata_s;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench: sequencer plus a behavioural register file/ALU,
// table-driven directed vectors, hand-written corner sequences, random commands.
module tb_datapath_sequencer;
    import datapath_seq_pkg::*;

    localparam int TB_CNTW = 10;

    logic        clock;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_kind;
    logic        cmd_wb;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rs1;
    logic [4:0]  cmd_rs2;
    logic [4:0]  cmd_alufn;
    logic [7:0]  cmd_imm;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_zero;
    logic        busy;
    logic [TB_CNTW-1:0] ops_count;
    logic        dp_RegWrite;
    logic [4:0]  dp_ReadAddr1;
    logic [4:0]  dp_ReadAddr2;
    logic [4:0]  dp_WriteAddr;
    logic [4:0]  dp_ALUFN;
    logic [7:0]  dp_WriteData;
    logic [7:0]  dp_ReadData1;
    logic [7:0]  dp_ReadData2;
    logic [7:0]  dp_ALUResult;
    logic        dp_FlagZ;

    int checks;
    int errors;

    datapath_sequencer #(.Nloc(32), .Dbits(8), .CNTW(TB_CNTW)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_wb(cmd_wb), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_alufn(cmd_alufn), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .busy(busy), .ops_count(ops_count),
        .dp_RegWrite(dp_RegWrite), .dp_ReadAddr1(dp_ReadAddr1),
        .dp_ReadAddr2(dp_ReadAddr2), .dp_WriteAddr(dp_WriteAddr),
        .dp_ALUFN(dp_ALUFN), .dp_WriteData(dp_WriteData),
        .dp_ReadData1(dp_ReadData1), .dp_ALUResult(dp_ALUResult),
        .dp_FlagZ(dp_FlagZ)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural datapath: combinational reads/ALU, write on the rising edge.
    logic [7:0] rf [32];
    logic       rf_clear;

    always @(posedge clock) begin
        if (rf_clear) begin
            for (int i = 0; i < 32; i++) rf[i] <= 8'h00;
        end else if (dp_RegWrite) begin
            rf[dp_WriteAddr] <= dp_WriteData;
        end
    end

    assign dp_ReadData1 = rf[dp_ReadAddr1];
    assign dp_ReadData2 = rf[dp_ReadAddr2];
    assign dp_ALUResult = (dp_ALUFN == ALUFN_ADD) ? dp_ReadData1 + dp_ReadData2 :
                          (dp_ALUFN == ALUFN_SUB) ? dp_ReadData1 - dp_ReadData2 :
                                                    dp_ReadData1 & dp_ReadData2;
    assign dp_FlagZ     = (dp_ALUResult == 8'h00);

    // Reference model: architectural register contents and response count.
    logic [7:0]  mrf [32];
    int unsigned mops;

    function automatic logic [7:0] ref_alu(input logic [4:0] fn, input logic [7:0] a, input logic [7:0] b);
        if (fn == ALUFN_ADD) return a + b;
        else if (fn == ALUFN_SUB) return a - b;
        else return a & b;
    endfunction

    task automatic model_cmd(input logic [1:0] k, input logic wb, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] fn,
                             input logic [7:0] imm, output logic [7:0] d, output logic z);
        logic [7:0] r;
        case (k)
            2'd1: begin mrf[rd] = imm; d = imm; end
            2'd2: begin r = ref_alu(fn, mrf[rs1], mrf[rs2]); if (wb) mrf[rd] = r; d = r; end
            2'd3: d = mrf[rs1];
            default: d = 8'h00;
        endcase
        z = (d == 8'h00);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input logic [1:0] k, input logic wb, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] fn,
                             input logic [7:0] imm);
        cmd_kind = k; cmd_wb = wb; cmd_rd = rd; cmd_rs1 = rs1;
        cmd_rs2 = rs2; cmd_alufn = fn; cmd_imm = imm; cmd_valid = 1'b1;
    endtask

    // One full command from an idle DUT (called just after a falling edge).
    task automatic do_cmd(input logic [1:0] k, input logic wb, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] fn,
                          input logic [7:0] imm, input logic [7:0] exp_d, input logic exp_z);
        int edges;
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        drive_cmd(k, wb, rd, rs1, rs2, fn, imm);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        edges = 1;
        chk("busy_exec", {31'd0, busy}, 32'd1);
        chk("cmd_ready_exec", {31'd0, cmd_ready}, 32'd0);
        chk("regwrite_exec", {31'd0, dp_RegWrite},
            {31'd0, (k == 2'd1) || ((k == 2'd2) && wb)});
        while (!rsp_valid && edges < 8) begin
            @(posedge clock); #1;
            edges++;
        end
        chk("rsp_latency", edges, 32'd2);
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_d});
        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, exp_z});
        chk("regwrite_resp", {31'd0, dp_RegWrite}, 32'd0);
        chk("readaddr1_hold", {27'd0, dp_ReadAddr1}, {27'd0, rs1});
        chk("writeaddr_hold", {27'd0, dp_WriteAddr}, {27'd0, rd});
        chk("alufn_hold", {27'd0, dp_ALUFN}, {27'd0, fn});
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        mops++;
        chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
        chk("ops_count", {{(32-TB_CNTW){1'b0}}, ops_count}, mops % (32'd1 << TB_CNTW));
        @(negedge clock);
    endtask

    typedef struct {
        logic [1:0] kind;
        logic       wb;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] fn;
        logic [7:0] imm;
        logic [7:0] exp_d;
        logic       exp_z;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [7:0] md;
        logic       mz;
        logic [1:0] rk;
        logic [4:0] rfn;
        checks = 0; errors = 0; mops = 0;
        for (int i = 0; i < 32; i++) mrf[i] = 8'h00;

        vecs[0]  = '{2'd1, 1'b0, 5'd3, 5'd0, 5'd0, 5'd0, 8'h25, 8'h25, 1'b0};
        vecs[1]  = '{2'd1, 1'b0, 5'd1, 5'd0, 5'd0, 5'd0, 8'h10, 8'h10, 1'b0};
        vecs[2]  = '{2'd1, 1'b0, 5'd2, 5'd0, 5'd0, 5'd0, 8'h05, 8'h05, 1'b0};
        vecs[3]  = '{2'd2, 1'b1, 5'd4, 5'd1, 5'd2, ALUFN_ADD, 8'h00, 8'h15, 1'b0};
        vecs[4]  = '{2'd3, 1'b0, 5'd0, 5'd4, 5'd0, 5'd0, 8'h00, 8'h15, 1'b0};
        vecs[5]  = '{2'd1, 1'b1, 5'd5, 5'd0, 5'd0, 5'd0, 8'h7F, 8'h7F, 1'b0};
        vecs[6]  = '{2'd2, 1'b0, 5'd5, 5'd2, 5'd2, ALUFN_SUB, 8'h00, 8'h00, 1'b1};
        vecs[7]  = '{2'd3, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 8'h00, 8'h7F, 1'b0};
        vecs[8]  = '{2'd0, 1'b1, 5'd9, 5'd3, 5'd1, 5'd7, 8'h44, 8'h00, 1'b1};
        vecs[9]  = '{2'd1, 1'b0, 5'd6, 5'd0, 5'd0, 5'd0, 8'h33, 8'h33, 1'b0};
        vecs[10] = '{2'd3, 1'b1, 5'd1, 5'd3, 5'd0, 5'd0, 8'h00, 8'h25, 1'b0};

        reset_n = 1'b0; rf_clear = 1'b1; rsp_ready = 1'b0;
        drive_cmd(2'd1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 8'h00);
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_regwrite", {31'd0, dp_RegWrite}, 32'd0);
        chk("rst_ops", {{(32-TB_CNTW){1'b0}}, ops_count}, 32'd0);
        chk("rst_rsp_data", {23'd0, rsp_zero, rsp_data}, 32'd0);
        @(posedge clock); #1;
        chk("rst_no_capture", {31'd0, busy}, 32'd0);
        rf_clear = 1'b0; cmd_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            model_cmd(vecs[i].kind, vecs[i].wb, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                      vecs[i].fn, vecs[i].imm, md, mz);
            do_cmd(vecs[i].kind, vecs[i].wb, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].fn, vecs[i].imm, vecs[i].exp_d, vecs[i].exp_z);
        end

        // Back-pressure: response held for 5 cycles while a command is offered.
        model_cmd(2'd1, 1'b0, 5'd8, 5'd0, 5'd0, 5'd0, 8'h5A, md, mz);
        drive_cmd(2'd1, 1'b0, 5'd8, 5'd0, 5'd0, 5'd0, 8'h5A);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        @(posedge clock); #1;
        chk("bp_rsp_valid_rise", {31'd0, rsp_valid}, 32'd1);
        drive_cmd(2'd3, 1'b0, 5'd0, 5'd8, 5'd0, 5'd0, 8'h00);
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data", {23'd0, rsp_zero, rsp_data}, 32'h05A);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        mops++;
        chk("bp_released", {30'd0, rsp_valid, cmd_ready}, 32'd1);
        @(posedge clock); #1;
        chk("bp_accepted", {30'd0, busy, cmd_ready}, 32'd2);
        cmd_valid = 1'b0;
        model_cmd(2'd3, 1'b0, 5'd0, 5'd8, 5'd0, 5'd0, 8'h00, md, mz);
        @(posedge clock); #1;
        chk("bp_read_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_read_data", {24'd0, rsp_data}, 32'h5A);
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        mops++;
        chk("bp_ops", {{(32-TB_CNTW){1'b0}}, ops_count}, mops % (32'd1 << TB_CNTW));
        @(negedge clock);

        // Reset during EXEC of LOADI r6=0xAA aborts the write and the response.
        drive_cmd(2'd1, 1'b0, 5'd6, 5'd0, 5'd0, 5'd0, 8'hAA);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        chk("abort_regwrite_before", {31'd0, dp_RegWrite}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_regwrite_drop", {31'd0, dp_RegWrite}, 32'd0);
        chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clock); #1;
        chk("abort_no_rsp", {30'd0, rsp_valid, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        mops = 0;
        chk("abort_ops", {{(32-TB_CNTW){1'b0}}, ops_count}, 32'd0);
        @(negedge clock);
        do_cmd(2'd3, 1'b0, 5'd0, 5'd6, 5'd0, 5'd0, 8'h00, 8'h33, 1'b0);

        // Random commands against the reference model.
        for (int n = 0; n < 300; n++) begin
            rk = 2'($urandom_range(3, 0));
            case ($urandom_range(2, 0))
                0: rfn = ALUFN_ADD;
                1: rfn = ALUFN_SUB;
                default: rfn = 5'($urandom_range(31, 0));
            endcase
            cmd_rd = 5'($urandom_range(31, 0));
            cmd_rs1 = 5'($urandom_range(31, 0));
            cmd_rs2 = 5'($urandom_range(31, 0));
            cmd_imm = 8'($urandom_range(255, 0));
            cmd_wb = 1'($urandom_range(1, 0));
            model_cmd(rk, cmd_wb, cmd_rd, cmd_rs1, cmd_rs2, rfn, cmd_imm, md, mz);
            do_cmd(rk, cmd_wb, cmd_rd, cmd_rs1, cmd_rs2, rfn, cmd_imm, md, mz);
        end

        // Counter wrap: from reset, 2^TB_CNTW NOP responses bring it back to 0.
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        mops = 0;
        @(negedge clock);
        for (int n = 0; n < (1 << TB_CNTW); n++) begin
            do_cmd(2'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 1'b1);
        end
        chk("ops_wrap", {{(32-TB_CNTW){1'b0}}, ops_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
